xylo_sequencer: RTL and testbench

Melody sequencer that drives the xylophone note decoder (`Notas`) directly. It steps through an internal melody table and holds each 4-bit note code on `a`,`b`,`c`,`d` for that note's duration in beats. It inserts a one-cycle rest between notes and reports `playing`/`done` status. It replaces hand-driven note inputs with a clocked source.

---
 rtl/xylo_sequencer.sv | 119 +++++++++++
 tb/tb_xylo_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/xylo_sequencer.sv
// Melody sequencer for the xylophone note decoder: plays a fixed melody table on a,b,c,d.
// Optional macro XYLO_LOOP_EN: when defined, the melody repeats forever instead of ending in DONE.
module xylo_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int LEN      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic playing,
  output logic done
);

  localparam int CW = $clog2(4 * TICK_DIV);
  localparam logic [3:0] REST = 4'b1111;
  localparam logic [3:0] LAST_IDX = 4'(LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

  state_t        state, next_state;
  logic [3:0]    idx, next_idx;
  logic [CW-1:0] cnt, next_cnt;
  logic [CW-1:0] last_cnt;
  logic [3:0]    code_q, next_code;
  logic          playing_q, next_playing;
  logic          done_q, next_done;

  // Note i lasts ((i mod 4)+1) beats; last_cnt is the final cycle of the current note.
  always_comb begin
    last_cnt = CW'(((int'(idx[1:0]) + 1) * TICK_DIV) - 1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      cnt       <= '0;
      code_q    <= REST;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= next_state;
      idx       <= next_idx;
      cnt       <= next_cnt;
      code_q    <= next_code;
      playing_q <= next_playing;
      done_q    <= next_done;
    end
  end

  // stop outranks everything, including start.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_cnt   = cnt;
    if (stop) begin
      next_state = S_IDLE;
      next_idx   = 4'd0;
      next_cnt   = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            next_state = S_PLAY;
            next_idx   = 4'd0;
            next_cnt   = '0;
          end
        end
        S_PLAY: begin
          if (cnt == last_cnt) begin
            next_state = S_GAP;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + CW'(1);
          end
        end
        S_GAP: begin
          next_cnt = '0;
          if (idx == LAST_IDX) begin
`ifdef XYLO_LOOP_EN
            next_state = S_PLAY;
            next_idx   = 4'd0;
`else
            next_state = S_DONE;
`endif
          end else begin
            next_state = S_PLAY;
            next_idx   = idx + 4'd1;
          end
        end
        default: begin
          next_state = S_IDLE;
          next_idx   = 4'd0;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet cycle-aligned with it.
  always_comb begin
    next_code    = (next_state == S_PLAY) ? next_idx : REST;
    next_playing = (next_state == S_PLAY) || (next_state == S_GAP);
    next_done    = (next_state == S_DONE);
  end

  assign a       = code_q[3];
  assign b       = code_q[2];
  assign c       = code_q[1];
  assign d       = code_q[0];
  assign playing = playing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_xylo_sequencer.sv
// Bench for xylo_sequencer: timeline-based reference model plus literal melody checks.
module tb_xylo_sequencer;

  localparam int TICK_DIV = 2;
  localparam int LEN      = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic a, b, c, d, playing, done;

  int vectors     = 0;
  int miscompares = 0;
  logic checking  = 1'b0;

  xylo_sequencer #(.TICK_DIV(TICK_DIV), .LEN(LEN)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .a(a), .b(b), .c(c), .d(d), .playing(playing), .done(done)
  );

  always #5 clock = ~clock;

  // Model: elapsed cycles since the accepted start, mapped onto the melody timeline.
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  int   m_t      = 0;

  function automatic int total_len();
    int s = 0;
    for (int i = 0; i < LEN; i++) s += ((i % 4) + 1) * TICK_DIV + 1;
    return s;
  endfunction

  function automatic logic [5:0] model_out();
    int tt;
    int dur;
    if (!m_active) return {4'hF, 1'b0, m_done};
    tt = m_t;
    for (int i = 0; i < LEN; i++) begin
      dur = ((i % 4) + 1) * TICK_DIV;
      if (tt < dur) return {4'(i), 1'b1, 1'b0};
      tt -= dur;
      if (tt == 0) return {4'hF, 1'b1, 1'b0};
      tt -= 1;
    end
    return {4'hF, 1'b0, 1'b1};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_done = 1'b0; m_t = 0;
    end else if (stop) begin
      m_active = 1'b0; m_done = 1'b0; m_t = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t == total_len()) begin
`ifdef XYLO_LOOP_EN
        m_t = 0;
`else
        m_active = 1'b0; m_done = 1'b1;
`endif
      end
    end else if (start) begin
      m_active = 1'b1; m_done = 1'b0; m_t = 0;
    end
  end

  function automatic logic [5:0] dut_out();
    return {a, b, c, d, playing, done};
  endfunction

  always @(negedge clock) begin
    if (checking) begin
      logic [5:0] exp_v;
      exp_v = model_out();
      vectors++;
      if (dut_out() !== exp_v) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got code=%b playing=%b done=%b expected code=%b playing=%b done=%b",
                 $time, dut_out()  >> 2, dut_out()[1], dut_out()[0], exp_v >> 2, exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [5:0] exp_v);
    vectors++;
    if (dut_out() !== exp_v) begin
      miscompares++;
      $display("FAIL %s t=%0t got {code,playing,done}=%b expected %b", name, $time, dut_out(), exp_v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  logic [5:0] exp_q[$];

  task automatic push_n(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Hand-written melody for TICK_DIV=2, LEN=4.
  task automatic literal_melody();
    exp_q.delete();
    push_n(6'b0000_1_0, 2); push_n(6'b1111_1_0, 1);
    push_n(6'b0001_1_0, 4); push_n(6'b1111_1_0, 1);
    push_n(6'b0010_1_0, 6); push_n(6'b1111_1_0, 1);
    push_n(6'b0011_1_0, 8); push_n(6'b1111_1_0, 1);
    push_n(6'b1111_0_1, 6);
    pulse_start();
    while (exp_q.size() > 0) begin
      check_lit("melody_seq", exp_q.pop_front());
      @(negedge clock);
    end
  endtask

  initial begin
    wait_neg(2);
    check_lit("reset_hold", 6'b1111_0_0);
    @(negedge clock); reset = 1'b0;
    checking = 1'b1;
    wait_neg(10);
    check_lit("idle_after_reset", 6'b1111_0_0);

    literal_melody();

    // stop during note 0010 (t=9), then restart
    pulse_start();
    wait_neg(9);
    check_lit("before_stop", 6'b0010_1_0);
    stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    check_lit("after_stop", 6'b1111_0_0);
    pulse_start();
    check_lit("restart_note0", 6'b0000_1_0);
    wait_neg(30);

    // start held through a whole melody and beyond
    @(negedge clock); start = 1'b1;
    wait_neg(total_len() + 8);
    start = 1'b0;
    wait_neg(30);

    // async reset between edges during note 0001
    pulse_start();
    wait_neg(4);
    check_lit("pre_reset_note1", 6'b0001_1_0);
    @(posedge clock); #2 reset = 1'b1;
    #1 check_lit("async_reset", 6'b1111_0_0);
    #1 reset = 1'b0;
    wait_neg(5);
    check_lit("idle_post_reset", 6'b1111_0_0);

    // randomized start/stop/reset traffic
    for (int k = 0; k < 1500; k++) begin
      @(negedge clock);
      start = ($urandom_range(0, 11) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    @(negedge clock); start = 1'b0; stop = 1'b0;
    wait_neg(3);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
